// File: rtl/nfu2_accum_stage_if.sv
// rtl/nfu2_accum_stage_if.sv - job control, product-beat and result-drain signals of the NFU-2 accumulate stage
interface nfu2_accum_stage_if #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int PASS_W    = 8
);
    logic                        i_start;
    logic [PASS_W-1:0]           i_num_passes;
    logic                        i_load_partial_sum;
    logic [Tn*BIT_WIDTH-1:0]     i_partial_sum;
    logic                        i_valid;
    logic                        o_ready;
    logic [Tn*Tn*BIT_WIDTH-1:0]  i_nfu1;
    logic [Tn*Tn-1:0]            i_mask;
    logic                        o_valid;
    logic                        i_out_ready;
    logic [Tn*BIT_WIDTH-1:0]     o_output;
    logic [Tn-1:0]               o_sat;
    logic                        o_busy;

    modport master (
        output i_start, i_num_passes, i_load_partial_sum, i_partial_sum,
        output i_valid, i_nfu1, i_mask, i_out_ready,
        input  o_ready, o_valid, o_output, o_sat, o_busy
    );

    modport slave (
        input  i_start, i_num_passes, i_load_partial_sum, i_partial_sum,
        input  i_valid, i_nfu1, i_mask, i_out_ready,
        output o_ready, o_valid, o_output, o_sat, o_busy
    );
endinterface

// File: rtl/nfu2_accum_stage.sv
// rtl/nfu2_accum_stage.sv - masked Tn x Tn product reduction with saturating multi-pass lane accumulation
module nfu2_accum_stage #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int PASS_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    nfu2_accum_stage_if.slave  bus
);
    localparam int SUM_W = BIT_WIDTH + $clog2(Tn);
    localparam int EXT_W = SUM_W + 1;
    localparam int LW    = Tn * BIT_WIDTH;
    localparam int NP    = Tn * Tn;

    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [PASS_W-1:0]      remaining_q, remaining_d;
    logic [NP*BIT_WIDTH-1:0] p1_q, p1_d;
    logic                   v1_q, v1_d;
    logic [Tn*SUM_W-1:0]    p2_q, p2_d;
    logic                   v2_q, v2_d;
    logic [LW-1:0]          acc_q, acc_d;
    logic [Tn-1:0]          sat_q, sat_d;
    logic                   accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain waits for the pipeline to empty so the last beat is in acc.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.i_start) state_d = ST_ACCUM;
            ST_ACCUM: if (remaining_q == '0 && !v1_q && !v2_q) state_d = ST_DRAIN;
            ST_DRAIN: if (bus.i_out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready = (state_q == ST_ACCUM) && (remaining_q != '0);
        bus.o_valid = (state_q == ST_DRAIN);
        bus.o_busy  = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    end

    assign bus.o_output = acc_q;
    assign bus.o_sat    = sat_q;
    assign accept       = (state_q == ST_ACCUM) && (remaining_q != '0) && bus.i_valid;

    always_comb begin
        logic signed [BIT_WIDTH-1:0] prod;
        logic signed [SUM_W-1:0]     lane_sum;
        logic signed [BIT_WIDTH-1:0] acc_lane;
        logic signed [SUM_W-1:0]     tree;
        logic signed [EXT_W-1:0]     total;

        prod        = '0;
        lane_sum    = '0;
        acc_lane    = '0;
        tree        = '0;
        total       = '0;
        remaining_d = remaining_q;
        p1_d        = p1_q;
        v1_d        = accept;
        p2_d        = p2_q;
        v2_d        = v1_q;
        acc_d       = acc_q;
        sat_d       = sat_q;

        if (state_q == ST_IDLE && bus.i_start) begin
            acc_d       = bus.i_load_partial_sum ? bus.i_partial_sum : '0;
            remaining_d = bus.i_num_passes;
            sat_d       = '0;
        end

        if (accept) begin
            remaining_d = remaining_q - PASS_W'(1);
            for (int i = 0; i < NP; i++) begin
                p1_d[i*BIT_WIDTH +: BIT_WIDTH] = bus.i_mask[i] ? bus.i_nfu1[i*BIT_WIDTH +: BIT_WIDTH] : '0;
            end
        end

        // SUM_W holds Tn full-scale products, so the tree itself never overflows.
        if (v1_q) begin
            for (int j = 0; j < Tn; j++) begin
                lane_sum = '0;
                for (int k = 0; k < Tn; k++) begin
                    prod     = p1_q[(j*Tn+k)*BIT_WIDTH +: BIT_WIDTH];
                    lane_sum = lane_sum + {{(SUM_W-BIT_WIDTH){prod[BIT_WIDTH-1]}}, prod};
                end
                p2_d[j*SUM_W +: SUM_W] = lane_sum;
            end
        end

        if (v2_q) begin
            for (int j = 0; j < Tn; j++) begin
                acc_lane = acc_q[j*BIT_WIDTH +: BIT_WIDTH];
                tree     = p2_q[j*SUM_W +: SUM_W];
                total    = {{(EXT_W-BIT_WIDTH){acc_lane[BIT_WIDTH-1]}}, acc_lane} + {tree[SUM_W-1], tree};
                if (total > SAT_MAX) begin
                    acc_d[j*BIT_WIDTH +: BIT_WIDTH] = SAT_MAX[BIT_WIDTH-1:0];
                    sat_d[j] = 1'b1;
                end else if (total < SAT_MIN) begin
                    acc_d[j*BIT_WIDTH +: BIT_WIDTH] = SAT_MIN[BIT_WIDTH-1:0];
                    sat_d[j] = 1'b1;
                end else begin
                    acc_d[j*BIT_WIDTH +: BIT_WIDTH] = total[BIT_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
            p1_q        <= '0;
            v1_q        <= 1'b0;
            p2_q        <= '0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            sat_q       <= '0;
        end else begin
            remaining_q <= remaining_d;
            p1_q        <= p1_d;
            v1_q        <= v1_d;
            p2_q        <= p2_d;
            v2_q        <= v2_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
        end
    end
endmodule

// File: tb/tb_nfu2_accum_stage.sv
// tb/tb_nfu2_accum_stage.sv - directed self-checking bench for nfu2_accum_stage with Tn=4, BIT_WIDTH=16
module tb_nfu2_accum_stage;
    localparam int BW = 16;
    localparam int TN = 4;
    localparam int PW = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   n_acc;
    int   cyc;

    nfu2_accum_stage_if #(.BIT_WIDTH(BW), .Tn(TN), .PASS_W(PW)) bus ();

    nfu2_accum_stage #(.BIT_WIDTH(BW), .Tn(TN), .PASS_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] lanes(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_prod(input logic [63:0] v);
        for (int j = 0; j < TN; j++)
            for (int k = 0; k < TN; k++)
                bus.i_nfu1[(j*TN+k)*BW +: BW] = v[j*BW +: BW];
    endtask

    task automatic start_job(input logic [PW-1:0] passes, input logic load, input logic [63:0] partial);
        bus.i_start            = 1'b1;
        bus.i_num_passes       = passes;
        bus.i_load_partial_sum = load;
        bus.i_partial_sum      = partial;
        step();
        bus.i_start            = 1'b0;
    endtask

    task automatic beat();
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        cyc = 0;
        while (!bus.o_valid && cyc < 50) begin
            step();
            cyc++;
        end
        chk(tag, bus.o_valid, 1'b1);
    endtask

    task automatic consume();
        bus.i_out_ready = 1'b1;
        step();
        bus.i_out_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst                    = 1'b1;
        bus.i_start            = 1'b0;
        bus.i_num_passes       = '0;
        bus.i_load_partial_sum = 1'b0;
        bus.i_partial_sum      = '0;
        bus.i_valid            = 1'b0;
        bus.i_nfu1             = '0;
        bus.i_mask             = '1;
        bus.i_out_ready        = 1'b0;
        step();
        step();
        chk("rst_ready", bus.o_ready, 1'b0);
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_output", bus.o_output, 64'h0);
        chk("rst_sat", bus.o_sat, 4'h0);
        rst = 1'b0;
        step();

        // Reset mid-job after two of four beats.
        set_prod(lanes(9, 9, 9, 9));
        start_job(8'd4, 1'b0, 64'h0);
        bus.i_valid = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_valid = 1'b0;
        chk("abort_busy", bus.o_busy, 1'b0);
        chk("abort_output", bus.o_output, 64'h0);
        step();
        step();
        step();
        chk("abort_no_stale", bus.o_output, 64'h0);
        chk("abort_valid", bus.o_valid, 1'b0);
        set_prod(lanes(1, 1, 1, 1));
        start_job(8'd1, 1'b0, 64'h0);
        beat();
        wait_valid("after_abort_valid");
        chk("after_abort_lanes", bus.o_output, lanes(4, 4, 4, 4));
        consume();

        // Single pass, lane j products = j+1, check exact latency.
        set_prod(lanes(1, 2, 3, 4));
        start_job(8'd1, 1'b0, 64'h0);
        chk("lat_ready", bus.o_ready, 1'b1);
        chk("lat_busy", bus.o_busy, 1'b1);
        beat();
        chk("lat_valid_e0", bus.o_valid, 1'b0);
        chk("lat_ready_done", bus.o_ready, 1'b0);
        step();
        step();
        chk("lat_valid_e2", bus.o_valid, 1'b0);
        chk("lat_acc_e2", bus.o_output, lanes(4, 8, 12, 16));
        step();
        chk("lat_valid_e3", bus.o_valid, 1'b1);
        chk("lat_lanes", bus.o_output, lanes(4, 8, 12, 16));
        chk("lat_sat", bus.o_sat, 4'h0);
        consume();
        chk("lat_idle_valid", bus.o_valid, 1'b0);
        chk("lat_idle_busy", bus.o_busy, 1'b0);

        // Three back-to-back passes with only product k=0 unmasked, preloaded 100.
        set_prod(lanes(1, 1, 1, 1));
        bus.i_mask = 16'h1111;
        start_job(8'd3, 1'b1, lanes(100, 100, 100, 100));
        n_acc = 0;
        bus.i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.o_ready) n_acc++;
            step();
        end
        bus.i_valid = 1'b0;
        chk("b2b_accepts", n_acc, 3);
        chk("b2b_ready_low", bus.o_ready, 1'b0);
        wait_valid("b2b_valid");
        chk("b2b_lanes", bus.o_output, lanes(103, 103, 103, 103));
        consume();
        bus.i_mask = '1;

        // Positive saturation on lane 0.
        set_prod(lanes(5, 0, 0, 0));
        start_job(8'd1, 1'b1, lanes(32760, 32760, 32760, 32760));
        beat();
        wait_valid("satp_valid");
        chk("satp_lanes", bus.o_output, lanes(16'h7FFF, 32760, 32760, 32760));
        chk("satp_flags", bus.o_sat, 4'b0001);
        consume();
        chk("satp_sticky_idle", bus.o_sat, 4'b0001);

        // Negative saturation on lane 0.
        set_prod(lanes(16'hFFFB, 0, 0, 0));
        start_job(8'd1, 1'b1, lanes(16'h8008, 16'h8008, 16'h8008, 16'h8008));
        chk("satn_cleared", bus.o_sat, 4'b0000);
        beat();
        wait_valid("satn_valid");
        chk("satn_lanes", bus.o_output, lanes(16'h8000, 16'h8008, 16'h8008, 16'h8008));
        chk("satn_flags", bus.o_sat, 4'b0001);
        consume();

        // Backpressure in DRAIN with ignored start pulses.
        set_prod(lanes(1, 2, 3, 4));
        start_job(8'd1, 1'b0, 64'h0);
        beat();
        wait_valid("bp_valid");
        for (int i = 0; i < 10; i++) begin
            bus.i_start            = i[0];
            bus.i_load_partial_sum = 1'b1;
            bus.i_partial_sum      = lanes(55, 55, 55, 55);
            step();
            chk("bp_hold_valid", bus.o_valid, 1'b1);
            chk("bp_hold_output", bus.o_output, lanes(4, 8, 12, 16));
        end
        bus.i_start = 1'b0;
        chk("bp_sat", bus.o_sat, 4'h0);
        consume();
        chk("bp_idle_valid", bus.o_valid, 1'b0);
        chk("bp_idle_busy", bus.o_busy, 1'b0);
        chk("bp_idle_output", bus.o_output, lanes(4, 8, 12, 16));

        // Zero passes with preload -7; beats must be ignored.
        set_prod(lanes(3, 3, 3, 3));
        start_job(8'd0, 1'b1, lanes(16'hFFF9, 16'hFFF9, 16'hFFF9, 16'hFFF9));
        chk("zp_busy", bus.o_busy, 1'b1);
        chk("zp_ready", bus.o_ready, 1'b0);
        chk("zp_valid_early", bus.o_valid, 1'b0);
        bus.i_valid = 1'b1;
        step();
        chk("zp_valid", bus.o_valid, 1'b1);
        chk("zp_lanes", bus.o_output, lanes(16'hFFF9, 16'hFFF9, 16'hFFF9, 16'hFFF9));
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = ~bus.i_valid;
            step();
            chk("zp_ready_never", bus.o_ready, 1'b0);
            chk("zp_hold", bus.o_output, lanes(16'hFFF9, 16'hFFF9, 16'hFFF9, 16'hFFF9));
        end
        bus.i_valid = 1'b0;
        consume();
        chk("zp_idle", bus.o_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nfu2_accum_stage.md
Name: nfu2_accum_stage

Overview:
- Parametrised successor to the NFU-2 partial-sum stage: reduces a Tn x Tn product array from NFU-1 into Tn lane sums and accumulates them over a programmed number of passes.
- Adds a start/valid/ready handshake, per-product zero-skip mask, pipelined adder tree, signed saturation with sticky flags, and a held result drain to NFU-3.
- Sits between the NFU-1 multiplier registers and the NFU-2/NFU-3 pipe register.

Parameters:
- BIT_WIDTH, 16, signed width of each product, partial sum and output lane.
- Tn, 16, number of lanes and products per lane; power of two, >= 2.
- PASS_W, 8, width of the pass count.
- SUM_W, BIT_WIDTH+log2(Tn), full-precision adder-tree result width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  begin a job; sampled only in IDLE.
- i_num_passes  in  PASS_W  product beats to accumulate; sampled with i_start.
- i_load_partial_sum  in  1  sampled with i_start; 1 = init acc from i_partial_sum, 0 = init to zero.
- i_partial_sum  in  Tn*BIT_WIDTH  initial partial sums, lane j at bits [j*BIT_WIDTH +: BIT_WIDTH].
- i_valid  in  1  product beat valid.
- o_ready  out  1  stage accepts a beat.
- i_nfu1  in  Tn*Tn*BIT_WIDTH  products; product k of lane j at index j*Tn+k.
- i_mask  in  Tn*Tn  1 = product contributes, 0 = treated as zero; same indexing.
- o_valid  out  1  result held on o_output.
- i_out_ready  in  1  downstream consumes the result.
- o_output  out  Tn*BIT_WIDTH  accumulated lane results.
- o_sat  out  Tn  sticky per-lane saturation flags for the current job.
- o_busy  out  1  high in ACCUM or DRAIN.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE; o_ready=0, o_valid=0, o_busy=0; o_output=0; o_sat=0; pass counter and pipeline valid bits cleared. In-flight beats are discarded. Reset mid-job aborts the job with no result.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE -> ACCUM on i_start. Same edge: acc <= i_partial_sum or 0, per i_load_partial_sum; remaining <= i_num_passes; o_sat <= 0.
- ACCUM: o_ready = (remaining != 0). A beat is accepted on an edge with i_valid & o_ready; remaining decrements. i_valid is ignored while o_ready=0.
- Pipeline stage P1: masked products registered together with valid bit v1.
- Pipeline stage P2: per-lane signed tree sum (SUM_W, no overflow possible) registered with valid bit v2.
- Accumulate: when v2=1, acc_j <= sat(acc_j + sum_j). The add is computed at SUM_W+1 bits and clamped to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1]. On clamp, o_sat[j] <= 1 (sticky).
- Latency: a beat accepted at edge E updates acc at edge E+2. Beats may be accepted back-to-back, one per cycle.
- ACCUM -> DRAIN when remaining==0, v1==0 and v2==0. With back-to-back beats, o_valid rises the cycle after the final beat's accumulate edge.
- i_num_passes=0: ACCUM -> DRAIN on the next edge; output equals the initial acc value.
- DRAIN: o_valid=1, o_output=acc, both stable until i_out_ready=1. The result is consumed on an edge with o_valid & i_out_ready, and the FSM returns to IDLE.
- i_start is ignored outside IDLE. A new job may start on the edge after return to IDLE.
- o_output is driven from acc in all states (acc after reset is 0). o_sat holds its value until the next start or reset.

Test Plan:
- Reset mid-ACCUM after 2 of 4 beats, then a new job with passes=1, load=0, all products 1, all mask 1 -> o_output lanes = Tn; no stale contribution.
- Tn=4, BW=16, passes=1, load=0, products lane j = j+1, all mask 1 -> o_valid 3 cycles after accept; lanes = {4,8,12,16}; o_sat=0.
- passes=3, load=1, i_partial_sum lanes=100, back-to-back beats of all-1 products, mask only k=0 set -> lanes=103; exactly 3 beats accepted; o_ready low afterwards.
- Saturation: load=1, partial=32760, passes=1, lane 0 products 5 each (Tn=4) -> lane0=32767, o_sat[0]=1; negative case -32760 with -5 products -> -32768.
- Backpressure: i_out_ready held 0 for 10 cycles in DRAIN -> o_valid/o_output stable; i_start pulses ignored; IDLE one cycle after i_out_ready=1.
- passes=0, load=1, partial=-7 -> DRAIN with lanes=-7; i_valid pulses ignored, o_ready never asserted.
